// File: rtl/cs_y_fifo.sv
// rtl/cs_y_fifo.sv - warm-up discard plus valid/ready FIFO buffering the CS Y sample stream
module cs_y_fifo #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           y_in,
    input  logic                       y_valid,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       warm,
    output logic                       overflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WCW-1:0] WARM_MAX  = WCW'(WARMUP);
    localparam logic [AW:0]    LVL_FULL  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [WCW-1:0]   wcnt;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign warm       = (wcnt == WARM_MAX);
    assign full       = (level == LVL_FULL);
    assign dout_valid = (level != '0);
    assign push       = y_valid & warm;
    assign pop        = dout_valid & dout_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign dout       = dout_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= y_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt     <= '0;
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (y_valid && !warm) begin
                wcnt <= wcnt + 1'b1;
            end
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr_en && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !wr_en) begin
                level <= level - 1'b1;
            end
        end
    end
endmodule

// File: doc/cs_y_fifo.md
# cs_y_fifo

Elastic output buffer directly downstream of the CS window filter. Accepts the 10-bit Y stream one sample per cycle, discards the warm-up samples produced while the 9-sample window is still filling, and presents the valid results to a consumer through a valid/ready handshake with a DEPTH-entry FIFO. Reports fill level and a sticky overflow flag when the consumer applies backpressure for too long.

## Interface
- WIDTH, 10, sample width; matches CS Y.
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- WARMUP, 8, number of leading valid samples discarded after reset.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- y_in  input  WIDTH  sample from CS Y.
- y_valid  input  1  y_in carries a new sample this cycle.
- dout  output  WIDTH  head-of-FIFO sample; 0 when empty.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- level  output  log2(DEPTH)+1  current entry count, 0..DEPTH.
- warm  output  1  warm-up complete; later valid samples are stored.
- overflow  output  1  sticky; a post-warm-up sample was dropped.

## Operation
- Warm-up counter wcnt, 0..WARMUP, saturating. Each cycle with y_valid=1 and wcnt<WARMUP: wcnt+1, sample discarded, nothing written. warm = (wcnt==WARMUP).
- WARMUP=0: warm=1 directly out of reset; first valid sample is stored.
- push = y_valid & warm. pop = dout_valid & dout_ready.
- Storage: DEPTH x WIDTH register array, write pointer wp and read pointer rp of log2(DEPTH) bits, wrapping modulo DEPTH; level counter held separately.
- push & ~full: write y_in at wp, wp+1.
- push & full & pop: write succeeds; the head leaves and the new sample is appended; level stays DEPTH.
- push & full & ~pop: sample dropped; overflow←1; wp and level unchanged.
- pop: rp+1. Pop while empty is impossible (dout_valid=0).
- level update: +1 on accepted push without pop, −1 on pop without push, unchanged otherwise.
- dout = mem[rp] when level≠0, else 0. Combinational from registered state only; no path from y_in or dout_ready to dout/dout_valid.
- No bypass: a sample pushed into an empty FIFO appears on dout the cycle after the push edge.
- overflow clears only on reset.
- Samples are never reordered or altered; values pass through bit-exact.

## Timing
- Reset (reset=0, asynchronous): wcnt=0, wp=rp=0, level=0, dout=0, dout_valid=0, warm=(WARMUP==0), overflow=0. Memory contents need not be cleared.
- Reset asserted mid-operation discards all buffered data and restarts warm-up. The first edge after reset deasserts behaves as a normal cycle.
- Push latency: sample with y_valid high at edge k → dout_valid=1 and dout=sample from edge k until the edge at which it is popped.
- Pop takes effect at the edge where dout_valid & dout_ready; the next entry, or 0/dout_valid=0, appears after that edge.
- With the CS producing one sample per cycle and dout_ready held high, throughput is 1 sample/cycle and level stays ≤1.
- warm rises after the edge that consumes the WARMUP-th valid sample.
- overflow rises after the edge on which the drop occurs.

## Test plan
- Reset/warm-up: reset=0 for 2 cycles, then y_valid=1 with y_in=0x001..0x00A on consecutive cycles, dout_ready=1. Required: all outputs 0 during reset; first 8 samples dropped; warm=1 after the 8th; dout shows 0x009 then 0x00A, each one cycle after its push; level ≤1.
- Streaming: after warm-up, 2000 consecutive samples with dout_ready=1. Required: dout sequence equals the input sequence delayed by 1 cycle; overflow=0.
- Fill/overflow: after warm-up, dout_ready=0, push 17 samples 0x100..0x110. Required: level reaches 16; the 17th (0x110) is dropped and overflow=1. Then dout_ready=1 with no pushes: dout drains 0x100..0x10F, dout_valid falls, and overflow stays 1.
- Full with simultaneous push/pop: FIFO full (16 entries), one cycle with push 0x3FF and dout_ready=1. Required: head popped, 0x3FF appended, level=16, overflow unchanged; 0x3FF emerges after 15 further pops.
- Pointer wrap: alternate bursts of 10 pushes / 10 pops for 5 rounds with random dout_ready. Required: data order is preserved across the wp/rp wrap, level matches the reference count every cycle, and dout=0 whenever level=0.
- Mid-run reset: FIFO holding 5 entries, pulse reset=0 asynchronously between edges. Required: level=0, dout_valid=0, warm=0, overflow=0 immediately; the next 8 valid samples are discarded again.
